risc_spm_control_unit: RTL and testbench

- Instruction-sequencing FSM that drives the 8-bit RISC-SPM datapath: fetch, decode, execute.
- Issues every register load strobe and both bus-mux selects, plus the memory write strobe.
- Receives the instruction register contents and the registered Z, overflow and multiply-done flags back from the datapath.
- Adds a bounded multiply-wait with an error halt.

---
 rtl/risc_spm_control_unit_if.sv | 51 +++++
 rtl/risc_spm_control_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_risc_spm_control_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/risc_spm_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : risc_spm_control_unit_if
//  Description : Control-unit <-> datapath bundle for the RISC-SPM: IR and
//                flags in, load strobes, bus-mux selects and memory write out.
//  Revision    : 1.0  initial release
// ============================================================================
interface risc_spm_control_unit_if #(
    parameter int WORD_SIZE = 8,
    parameter int SEL1_SIZE = 3,
    parameter int SEL2_SIZE = 3
);
    logic [WORD_SIZE-1:0] instruction;
    logic                 Zflag;
    logic                 ovflag;
    logic                 mdflag;
    logic                 Load_R0;
    logic                 Load_R1;
    logic                 Load_R2;
    logic                 Load_R3;
    logic                 Load_PC;
    logic                 Inc_PC;
    logic [SEL1_SIZE-1:0] Sel_Bus_1_Mux;
    logic [SEL2_SIZE-1:0] Sel_Bus_2_Mux;
    logic                 Load_IR;
    logic                 Load_Add_R;
    logic                 Load_Reg_Y;
    logic                 Load_Reg_Z;
    logic                 Load_Reg_ov;
    logic                 Load_Reg_md;
    logic                 write;
    logic                 halted;
    logic                 mul_err;

    modport master (
        input  instruction, Zflag, ovflag, mdflag,
        output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
        output Sel_Bus_1_Mux, Sel_Bus_2_Mux,
        output Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, Load_Reg_ov, Load_Reg_md,
        output write, halted, mul_err
    );

    modport slave (
        output instruction, Zflag, ovflag, mdflag,
        input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
        input  Sel_Bus_1_Mux, Sel_Bus_2_Mux,
        input  Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, Load_Reg_ov, Load_Reg_md,
        input  write, halted, mul_err
    );
endinterface
`default_nettype wire

// File: rtl/risc_spm_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : risc_spm_control_unit
//  Description : Fetch/decode/execute sequencer for the 8-bit RISC-SPM, with a
//                bounded multiply wait that halts and flags an error on timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module risc_spm_control_unit #(
    parameter int WORD_SIZE   = 8,
    parameter int OP_SIZE     = 4,
    parameter int SEL1_SIZE   = 3,
    parameter int SEL2_SIZE   = 3,
    parameter int MUL_TIMEOUT = 15
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    risc_spm_control_unit_if.master      bus
);

    localparam int c_cnt_w = $clog2(MUL_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(MUL_TIMEOUT);

    localparam logic [3:0] c_s_idle   = 4'd0;
    localparam logic [3:0] c_s_fet1   = 4'd1;
    localparam logic [3:0] c_s_fet2   = 4'd2;
    localparam logic [3:0] c_s_dec    = 4'd3;
    localparam logic [3:0] c_s_ex1    = 4'd4;
    localparam logic [3:0] c_s_rd1    = 4'd5;
    localparam logic [3:0] c_s_rd2    = 4'd6;
    localparam logic [3:0] c_s_wr1    = 4'd7;
    localparam logic [3:0] c_s_wr2    = 4'd8;
    localparam logic [3:0] c_s_br1    = 4'd9;
    localparam logic [3:0] c_s_br2    = 4'd10;
    localparam logic [3:0] c_s_mul    = 4'd11;
    localparam logic [3:0] c_s_mul_lo = 4'd12;
    localparam logic [3:0] c_s_mul_hi = 4'd13;
    localparam logic [3:0] c_s_halt   = 4'd14;

    localparam logic [OP_SIZE-1:0] c_op_nop = OP_SIZE'(4'h0);
    localparam logic [OP_SIZE-1:0] c_op_add = OP_SIZE'(4'h1);
    localparam logic [OP_SIZE-1:0] c_op_sub = OP_SIZE'(4'h2);
    localparam logic [OP_SIZE-1:0] c_op_and = OP_SIZE'(4'h3);
    localparam logic [OP_SIZE-1:0] c_op_not = OP_SIZE'(4'h4);
    localparam logic [OP_SIZE-1:0] c_op_rd  = OP_SIZE'(4'h5);
    localparam logic [OP_SIZE-1:0] c_op_wr  = OP_SIZE'(4'h6);
    localparam logic [OP_SIZE-1:0] c_op_br  = OP_SIZE'(4'h7);
    localparam logic [OP_SIZE-1:0] c_op_brz = OP_SIZE'(4'h8);
    localparam logic [OP_SIZE-1:0] c_op_mul = OP_SIZE'(4'h9);
    localparam logic [OP_SIZE-1:0] c_op_brv = OP_SIZE'(4'hA);

    localparam logic [SEL1_SIZE-1:0] c_sel1_pc   = SEL1_SIZE'(4);
    localparam logic [SEL2_SIZE-1:0] c_sel2_alu  = SEL2_SIZE'(0);
    localparam logic [SEL2_SIZE-1:0] c_sel2_bus1 = SEL2_SIZE'(1);
    localparam logic [SEL2_SIZE-1:0] c_sel2_mem  = SEL2_SIZE'(2);
    localparam logic [SEL2_SIZE-1:0] c_sel2_mlo  = SEL2_SIZE'(3);
    localparam logic [SEL2_SIZE-1:0] c_sel2_mhi  = SEL2_SIZE'(4);

    logic [3:0]           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_mul_err;

    logic [OP_SIZE-1:0]   w_opcode;
    logic [1:0]           w_src;
    logic [1:0]           w_dest;
    logic [3:0]           w_load_r;
    logic                 w_load_pc;
    logic                 w_inc_pc;
    logic [SEL1_SIZE-1:0] w_sel1;
    logic [SEL2_SIZE-1:0] w_sel2;
    logic                 w_load_ir;
    logic                 w_load_add_r;
    logic                 w_load_y;
    logic                 w_load_z;
    logic                 w_load_ov;
    logic                 w_load_md;
    logic                 w_write;

    assign w_opcode = bus.instruction[WORD_SIZE-1 -: OP_SIZE];
    assign w_src    = bus.instruction[3:2];
    assign w_dest   = bus.instruction[1:0];

    // Output decode: pure function of state, IR and flags.
    always_comb begin
        w_load_r     = 4'b0000;
        w_load_pc    = 1'b0;
        w_inc_pc     = 1'b0;
        w_sel1       = '0;
        w_sel2       = '0;
        w_load_ir    = 1'b0;
        w_load_add_r = 1'b0;
        w_load_y     = 1'b0;
        w_load_z     = 1'b0;
        w_load_ov    = 1'b0;
        w_load_md    = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            c_s_fet1: begin
                w_sel1       = c_sel1_pc;
                w_sel2       = c_sel2_bus1;
                w_load_add_r = 1'b1;
            end
            c_s_fet2: begin
                w_sel2    = c_sel2_mem;
                w_load_ir = 1'b1;
                w_inc_pc  = 1'b1;
            end
            c_s_dec: begin
                case (w_opcode)
                    c_op_add, c_op_sub, c_op_and, c_op_mul: begin
                        w_sel1   = SEL1_SIZE'(w_src);
                        w_sel2   = c_sel2_bus1;
                        w_load_y = 1'b1;
                    end
                    c_op_not: begin
                        w_sel1           = SEL1_SIZE'(w_src);
                        w_sel2           = c_sel2_alu;
                        w_load_z         = 1'b1;
                        w_load_r[w_dest] = 1'b1;
                    end
                    c_op_rd, c_op_wr, c_op_br: begin
                        w_sel1       = c_sel1_pc;
                        w_sel2       = c_sel2_bus1;
                        w_load_add_r = 1'b1;
                    end
                    c_op_brz, c_op_brv: begin
                        // Untaken conditional branch steps over its operand byte.
                        if ((w_opcode == c_op_brz) ? bus.Zflag : bus.ovflag) begin
                            w_sel1       = c_sel1_pc;
                            w_sel2       = c_sel2_bus1;
                            w_load_add_r = 1'b1;
                        end else begin
                            w_inc_pc = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            c_s_ex1: begin
                w_sel1           = SEL1_SIZE'(w_dest);
                w_sel2           = c_sel2_alu;
                w_load_z         = 1'b1;
                w_load_ov        = (w_opcode == c_op_add) || (w_opcode == c_op_sub);
                w_load_r[w_dest] = 1'b1;
            end
            c_s_rd1, c_s_wr1: begin
                w_sel2       = c_sel2_mem;
                w_load_add_r = 1'b1;
                w_inc_pc     = 1'b1;
            end
            c_s_rd2: begin
                w_sel2           = c_sel2_mem;
                w_load_r[w_dest] = 1'b1;
            end
            c_s_wr2: begin
                w_sel1  = SEL1_SIZE'(w_src);
                w_write = 1'b1;
            end
            c_s_br1: begin
                w_sel2       = c_sel2_mem;
                w_load_add_r = 1'b1;
            end
            c_s_br2: begin
                w_sel2    = c_sel2_mem;
                w_load_pc = 1'b1;
            end
            c_s_mul: begin
                w_sel1    = SEL1_SIZE'(w_dest);
                w_load_md = 1'b1;
            end
            c_s_mul_lo: begin
                w_sel2           = c_sel2_mlo;
                w_load_r[w_dest] = 1'b1;
            end
            c_s_mul_hi: begin
                w_sel2          = c_sel2_mhi;
                w_load_r[w_src] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_s_idle;
            r_cnt     <= '0;
            r_mul_err <= 1'b0;
        end else begin
            case (r_state)
                c_s_idle: r_state <= c_s_fet1;
                c_s_fet1: r_state <= c_s_fet2;
                c_s_fet2: r_state <= c_s_dec;
                c_s_dec: begin
                    case (w_opcode)
                        c_op_nop, c_op_not:           r_state <= c_s_fet1;
                        c_op_add, c_op_sub, c_op_and: r_state <= c_s_ex1;
                        c_op_rd:                      r_state <= c_s_rd1;
                        c_op_wr:                      r_state <= c_s_wr1;
                        c_op_br:                      r_state <= c_s_br1;
                        c_op_brz: r_state <= bus.Zflag  ? c_s_br1 : c_s_fet1;
                        c_op_brv: r_state <= bus.ovflag ? c_s_br1 : c_s_fet1;
                        c_op_mul: begin
                            r_cnt   <= '0;
                            r_state <= c_s_mul;
                        end
                        default:                      r_state <= c_s_halt;
                    endcase
                end
                c_s_rd1: r_state <= c_s_rd2;
                c_s_wr1: r_state <= c_s_wr2;
                c_s_br1: r_state <= c_s_br2;
                c_s_ex1, c_s_rd2, c_s_wr2, c_s_br2, c_s_mul_hi: r_state <= c_s_fet1;
                c_s_mul: begin
                    // A completing multiply wins over a simultaneous timeout.
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.mdflag) begin
                        r_state <= c_s_mul_lo;
                    end else if (r_cnt == c_timeout) begin
                        r_state   <= c_s_halt;
                        r_mul_err <= 1'b1;
                    end
                end
                c_s_mul_lo: r_state <= c_s_mul_hi;
                c_s_halt:   r_state <= c_s_halt;
                default:    r_state <= c_s_idle;
            endcase
        end
    end

    assign bus.Load_R0       = w_load_r[0];
    assign bus.Load_R1       = w_load_r[1];
    assign bus.Load_R2       = w_load_r[2];
    assign bus.Load_R3       = w_load_r[3];
    assign bus.Load_PC       = w_load_pc;
    assign bus.Inc_PC        = w_inc_pc;
    assign bus.Sel_Bus_1_Mux = w_sel1;
    assign bus.Sel_Bus_2_Mux = w_sel2;
    assign bus.Load_IR       = w_load_ir;
    assign bus.Load_Add_R    = w_load_add_r;
    assign bus.Load_Reg_Y    = w_load_y;
    assign bus.Load_Reg_Z    = w_load_z;
    assign bus.Load_Reg_ov   = w_load_ov;
    assign bus.Load_Reg_md   = w_load_md;
    assign bus.write         = w_write;
    assign bus.halted        = (r_state == c_s_halt);
    assign bus.mul_err       = r_mul_err;

endmodule
`default_nettype wire

// File: tb/tb_risc_spm_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc_spm_control_unit
//  Description : Directed plus random instruction streams compared cycle by
//                cycle against a per-instruction expected-strobe model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_risc_spm_control_unit;

    localparam int MUL_TIMEOUT = 15;

    // Expected-vector bit layout, mirrored by w_got below.
    localparam logic [20:0] B_PC   = 21'd1 << 16;
    localparam logic [20:0] B_INC  = 21'd1 << 15;
    localparam logic [20:0] B_IR   = 21'd1 << 8;
    localparam logic [20:0] B_ADDR = 21'd1 << 7;
    localparam logic [20:0] B_Y    = 21'd1 << 6;
    localparam logic [20:0] B_Z    = 21'd1 << 5;
    localparam logic [20:0] B_OV   = 21'd1 << 4;
    localparam logic [20:0] B_MD   = 21'd1 << 3;
    localparam logic [20:0] B_WR   = 21'd1 << 2;
    localparam logic [20:0] B_HALT = 21'd1 << 1;
    localparam logic [20:0] B_MERR = 21'd1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [20:0] exp_q[$];
    bit          ends_halted;

    always #5 clk = ~clk;

    risc_spm_control_unit_if bus ();

    risc_spm_control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [20:0] w_got = {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0,
                         bus.Load_PC, bus.Inc_PC, bus.Sel_Bus_1_Mux, bus.Sel_Bus_2_Mux,
                         bus.Load_IR, bus.Load_Add_R, bus.Load_Reg_Y, bus.Load_Reg_Z,
                         bus.Load_Reg_ov, bus.Load_Reg_md, bus.write, bus.halted,
                         bus.mul_err};

    function automatic logic [20:0] s1(input logic [2:0] s);
        return {6'b0, s, 12'b0};
    endfunction

    function automatic logic [20:0] s2(input logic [2:0] s);
        return {9'b0, s, 9'b0};
    endfunction

    function automatic logic [20:0] ld(input logic [1:0] n);
        return 21'd1 << (17 + int'(n));
    endfunction

    // Expected strobe sequence of one instruction, from its own fetch onwards.
    function automatic void build(input logic [7:0] ins, input bit z, input bit v, input int w);
        logic [3:0] op  = ins[7:4];
        logic [1:0] src = ins[3:2];
        logic [1:0] dst = ins[1:0];
        bit taken;
        exp_q.delete();
        ends_halted = 1'b0;
        exp_q.push_back(s1(3'd4) | s2(3'd1) | B_ADDR);
        exp_q.push_back(s2(3'd2) | B_IR | B_INC);
        taken = (op == 4'h7) || (op == 4'h8 && z) || (op == 4'hA && v);
        if (op == 4'h0) begin
            exp_q.push_back('0);
        end else if (op >= 4'h1 && op <= 4'h3) begin
            exp_q.push_back(s1({1'b0, src}) | s2(3'd1) | B_Y);
            exp_q.push_back(s1({1'b0, dst}) | B_Z | ((op <= 4'h2) ? B_OV : 21'd0) | ld(dst));
        end else if (op == 4'h4) begin
            exp_q.push_back(s1({1'b0, src}) | B_Z | ld(dst));
        end else if (op == 4'h5 || op == 4'h6 || taken) begin
            exp_q.push_back(s1(3'd4) | s2(3'd1) | B_ADDR);
            if (op == 4'h5) begin
                exp_q.push_back(s2(3'd2) | B_ADDR | B_INC);
                exp_q.push_back(s2(3'd2) | ld(dst));
            end else if (op == 4'h6) begin
                exp_q.push_back(s2(3'd2) | B_ADDR | B_INC);
                exp_q.push_back(s1({1'b0, src}) | B_WR);
            end else begin
                exp_q.push_back(s2(3'd2) | B_ADDR);
                exp_q.push_back(s2(3'd2) | B_PC);
            end
        end else if (op == 4'h8 || op == 4'hA) begin
            exp_q.push_back(B_INC);
        end else if (op == 4'h9) begin
            exp_q.push_back(s1({1'b0, src}) | s2(3'd1) | B_Y);
            if (w <= MUL_TIMEOUT) begin
                for (int k = 0; k <= w; k++) exp_q.push_back(s1({1'b0, dst}) | B_MD);
                exp_q.push_back(s2(3'd3) | ld(dst));
                exp_q.push_back(s2(3'd4) | ld(src));
            end else begin
                for (int k = 0; k <= MUL_TIMEOUT; k++) exp_q.push_back(s1({1'b0, dst}) | B_MD);
                for (int k = 0; k < 3; k++) exp_q.push_back(B_HALT | B_MERR);
                ends_halted = 1'b1;
            end
        end else begin
            exp_q.push_back('0);
            for (int k = 0; k < 3; k++) exp_q.push_back(B_HALT);
            ends_halted = 1'b1;
        end
    endfunction

    task automatic check(input logic [20:0] expv, input string tag);
        @(negedge clk);
        checks++;
        assert (w_got === expv)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, w_got, expv);
        end
        @(posedge clk);
        #1;
    endtask

    // rst_at: -1 none, -2 random cycle, else the cycle index to reset in.
    task automatic run_instr(input logic [7:0] ins, input bit z, input bit v,
                             input int w, input int rst_at);
        int ra = rst_at;
        build(ins, z, v, w);
        if (ra == -2) ra = $urandom_range(0, exp_q.size() - 1);
        if (ends_halted && ra < 0) ra = exp_q.size() - 1;
        bus.instruction = ins;
        bus.Zflag       = z;
        bus.ovflag      = v;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (ins[7:4] == 4'h9) bus.mdflag = (i >= 3) && ((i - 3) >= w);
            else                  bus.mdflag = 1'($urandom);
            rst = (i == ra);
            check(exp_q[i], $sformatf("ins=%h cyc=%0d", ins, i));
            if (i == ra) begin
                rst = 1'b0;
                check('0, $sformatf("idle_after_rst ins=%h cyc=%0d", ins, i));
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] ins;
        rst             = 1'b1;
        bus.instruction = 8'h00;
        bus.Zflag       = 1'b0;
        bus.ovflag      = 1'b0;
        bus.mdflag      = 1'b0;
        @(posedge clk);
        #1;
        check('0, "reset_hold");
        rst = 1'b0;
        check('0, "idle");

        run_instr(8'h16, 1'b0, 1'b0, 0, -1);
        run_instr(8'h53, 1'b0, 1'b0, 0, -1);
        run_instr(8'h64, 1'b0, 1'b0, 0, -1);
        run_instr(8'h80, 1'b0, 1'b0, 0, -1);
        run_instr(8'h80, 1'b1, 1'b0, 0, -1);
        run_instr(8'hA0, 1'b1, 1'b0, 0, -1);
        run_instr(8'hA0, 1'b0, 1'b1, 0, -1);
        run_instr(8'h4B, 1'b0, 1'b0, 0, -1);
        run_instr(8'h27, 1'b0, 1'b0, 0, -1);
        run_instr(8'h3C, 1'b0, 1'b0, 0, -1);
        run_instr(8'h00, 1'b0, 1'b0, 0, -1);
        run_instr(8'h72, 1'b0, 1'b0, 0, -1);
        run_instr(8'h9E, 1'b0, 1'b0, 4, -1);
        run_instr(8'h95, 1'b0, 1'b0, 0, -1);
        run_instr(8'h9E, 1'b0, 1'b0, MUL_TIMEOUT, -1);
        run_instr(8'h9E, 1'b0, 1'b0, MUL_TIMEOUT + 1, -1);
        run_instr(8'hF0, 1'b0, 1'b0, 0, -1);
        run_instr(8'hB5, 1'b0, 1'b0, 0, -1);
        run_instr(8'h9E, 1'b0, 1'b0, 8, 7);
        run_instr(8'h53, 1'b0, 1'b0, 0, 1);

        for (int n = 0; n < 250; n++) begin
            ins = 8'($urandom);
            if (ins[7:4] > 4'hA && ($urandom % 4) != 0) ins[7:4] = 4'($urandom_range(0, 10));
            run_instr(ins, 1'($urandom), 1'($urandom), $urandom_range(0, MUL_TIMEOUT + 3),
                      (($urandom % 8) == 0) ? -2 : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
